quad_encoder_gen: RTL
=====================

Name: quad_encoder_gen

Overview:
- Generates quadrature phase A/B waveforms from step commands. It is the transmit side of the rotary-encoder decoder path.
- Used as a loopback stimulus source: drives the decoder from FPGA pins or within a bench.
- Also drives external quadrature inputs, e.g. motor-controller emulation.
- Accepts one command at a time over a valid/ready handshake. Each command is a direction plus a step count. Edges are emitted at a fixed, parameterised spacing.

Parameters:
p_STEP_WIDTH, 8, width of the step-count field in a command
p_DIV, 1000, clocks between consecutive phase edges (legal range 1..2^20)
p_EDGES, 4, phase edges per step (1 = one edge per step, 4 = full detent cycle returning to rest)

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
i_valid  input  1  command valid
i_cw  input  1  direction of command: 1 = clockwise, 0 = counter-clockwise
i_steps  input  p_STEP_WIDTH  number of steps in command
o_ready  output  1  block can accept a command
o_busy  output  1  command in progress
o_done  output  1  one-cycle pulse at command completion
o_phase_a  output  1  quadrature phase A (registered)
o_phase_b  output  1  quadrature phase B (registered)

Behaviour:
- Reset (async assert, sync deassert effect):
  - o_phase_a = o_phase_b = 0, o_ready = 1, o_busy = 0, o_done = 0.
  - Internal counters cleared. Any in-flight command is discarded.
- Phase sequence, written as {A,B}:
  - CW: 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  - CCW: exact reverse. Only one phase toggles per edge.
  - Phase state is held between commands; sequences continue from the current state.
- States: IDLE, EDGE, GAP, DONE.
- IDLE:
  - o_ready = 1, o_busy = 0.
  - Acceptance occurs when i_valid && o_ready at a rising edge. i_cw and i_steps are latched.
  - Edge budget = i_steps * p_EDGES, held in a counter of width p_STEP_WIDTH + 3.
  - Budget 0 -> DONE. Otherwise -> EDGE.
- EDGE:
  - Lasts exactly one cycle. Advances the phase by one position in the latched direction.
  - Decrements the edge budget, loads the spacing counter with p_DIV - 1, then -> GAP.
  - The first edge is visible on the outputs 1 cycle after the acceptance cycle.
- GAP:
  - The spacing counter decrements each cycle.
  - When it reaches 0: -> EDGE if budget > 0, else -> DONE.
  - Consecutive edges are exactly p_DIV clocks apart.
  - The last edge is followed by p_DIV clocks of hold before DONE.
- DONE:
  - One cycle. o_done = 1, then -> IDLE.
  - o_ready returns to 1 on the cycle after o_done.
- o_ready = 0 and o_busy = 1 in EDGE, GAP and DONE.
  - i_valid is ignored while o_ready = 0. No queuing; the source must hold i_valid.
- p_DIV = 1: one edge per cycle, no idle cycles between edges. Counter compare must not underflow.
- Maximum i_steps (all ones): the budget counter must not overflow (sized as above).
- Latency for N steps: o_done asserted at acceptance cycle + N * p_EDGES * p_DIV + 1. For N = 0: acceptance cycle + 1.
- With p_EDGES = 4, phase returns to its starting value after every complete step.
- Reset asserted mid-command: phases forced to 00 immediately. No o_done pulse.

Optional Feature:
QUAD_POS_EN:
- Enabled: adds output o_pos, signed, p_STEP_WIDTH + 8 bits.
  - Reset to 0.
  - +1 on every EDGE cycle with latched i_cw = 1, -1 with latched i_cw = 0.
  - Updated in the same cycle as the phase outputs. Two's-complement wrap on overflow.
- Disabled: port and counter absent. All other behaviour identical.

Test Plan:
1. Accept CW, i_steps = 1, with p_DIV = 4, p_EDGES = 4, from reset -> {A,B} = 10, 11, 01, 00 at acceptance +1, +5, +9, +13; o_done at +17.
2. CCW, i_steps = 2 from phase 00 -> {A,B} sequence 01, 11, 10, 00, 01, 11, 10, 00, edges 4 clocks apart; o_done once; o_ready low throughout.
3. i_steps = 0 -> o_done exactly 1 cycle after acceptance; no phase change; o_ready high again the following cycle.
4. i_valid held high during a busy command with different i_cw/i_steps -> ignored until o_ready = 1; second command then accepted on the first ready cycle.
5. RST_N pulsed low during GAP after 3 edges -> phases 00 immediately, o_busy = 0, o_ready = 1, no o_done.
6. p_DIV = 1, p_EDGES = 1, CW, i_steps = 255 -> 255 consecutive single-cycle edges; with QUAD_POS_EN, o_pos = 255.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B waveform generator driven by {direction, step count} commands.
// Ports: CLK, RST_N (async active-low), i_valid/i_cw/i_steps command in,
//   o_ready/o_busy/o_done status, o_phase_a/o_phase_b registered phases,
//   o_pos signed edge position (only when QUAD_POS_EN is defined).
module quad_encoder_gen #(
    parameter int unsigned p_STEP_WIDTH = 8,
    parameter int unsigned p_DIV        = 1000,
    parameter int unsigned p_EDGES      = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    i_valid,
    input  logic                    i_cw,
    input  logic [p_STEP_WIDTH-1:0] i_steps,
    output logic                    o_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_phase_a,
    output logic                    o_phase_b
`ifdef QUAD_POS_EN
    ,
    output logic signed [p_STEP_WIDTH+7:0] o_pos
`endif
);

    localparam int unsigned BW = p_STEP_WIDTH + 3;
    localparam int unsigned DW = (p_DIV > 1) ? $clog2(p_DIV) : 1;
    localparam logic [DW-1:0] DIV_M1  = DW'(p_DIV - 1);
    localparam logic [DW-1:0] CNT_ONE = DW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EDGE = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] budget_q, budget_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          pha_q, pha_d;
    logic          phb_q, phb_d;
    logic [BW-1:0] budget_init;
    logic          fire;
    logic          dir_use;

`ifdef QUAD_POS_EN
    logic signed [p_STEP_WIDTH+7:0] pos_q, pos_d;
`endif

    assign budget_init = BW'(i_steps) * BW'(p_EDGES);

    // The edge is applied on the clock that enters EDGE, so the EDGE
    // cycle is the one that shows the new phase. During IDLE the
    // direction has not been latched yet, so take it from the input.
    assign dir_use = (state_q == S_IDLE) ? i_cw : dir_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            budget_q <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            pha_q    <= 1'b0;
            phb_q    <= 1'b0;
`ifdef QUAD_POS_EN
            pos_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            budget_q <= budget_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            pha_q    <= pha_d;
            phb_q    <= phb_d;
`ifdef QUAD_POS_EN
            pos_q    <= pos_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        budget_d = budget_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        fire     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    dir_d = i_cw;
                    if (budget_init == '0) begin
                        state_d = S_DONE;
                    end else begin
                        fire     = 1'b1;
                        budget_d = budget_init - BW'(1);
                        state_d  = S_EDGE;
                    end
                end
            end
            S_EDGE: begin
                if (p_DIV == 1) begin
                    // No spacing: back-to-back edges.
                    if (budget_q != '0) begin
                        fire     = 1'b1;
                        budget_d = budget_q - BW'(1);
                        state_d  = S_EDGE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d   = DIV_M1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Leave as the counter reaches zero; <= guards underflow.
                if (cnt_q <= CNT_ONE) begin
                    cnt_d = '0;
                    if (budget_q != '0) begin
                        fire     = 1'b1;
                        budget_d = budget_q - BW'(1);
                        state_d  = S_EDGE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Gray step: CW toggles A when A==B, else B; CCW is the mirror.
    always_comb begin
        pha_d = pha_q;
        phb_d = phb_q;
        if (fire) begin
            if ((pha_q == phb_q) == dir_use) begin
                pha_d = ~pha_q;
            end else begin
                phb_d = ~phb_q;
            end
        end
    end

`ifdef QUAD_POS_EN
    always_comb begin
        pos_d = pos_q;
        if (fire) begin
            if (dir_use) begin
                pos_d = pos_q + (p_STEP_WIDTH+8)'(1);
            end else begin
                pos_d = pos_q - (p_STEP_WIDTH+8)'(1);
            end
        end
    end

    assign o_pos = pos_q;
`endif

    assign o_ready   = (state_q == S_IDLE);
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = (state_q == S_DONE);
    assign o_phase_a = pha_q;
    assign o_phase_b = phb_q;

endmodule
